// File: rtl/phase_rot_arbiter_pkg.sv
// Shared types and helpers for the phase rotator arbiter: phase type, stat width, rotate-right.
package phase_pkg;

   typedef logic [1:0] k_t;

   localparam int STAT_W   = 16;
   // Widest bitstream the rotate helper handles; BITSTREAM must not exceed it.
   localparam int MAX_BITS = 256;
   localparam int MAX_LOG  = $clog2(MAX_BITS);

   // Rotate the low 'width' bits right by k: bit j lands on (j-k) mod width.
   function automatic logic [MAX_BITS-1:0] rot_r(input logic [MAX_BITS-1:0] bits,
                                                 input int unsigned          width,
                                                 input k_t                   k);
      logic [MAX_BITS-1:0] r;
      int unsigned         idx;
      r = '0;
      for (int unsigned j = 0; j < MAX_BITS; j++) begin
         if (j < width) begin
            idx = j + int'(k);
            if (idx >= width) idx = idx - width;
            r[j[MAX_LOG-1:0]] = bits[idx[MAX_LOG-1:0]];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/phase_rot_arbiter_rr_arb.sv
// Round-robin priority scan: first asserted req at or after ptr (mod NREQ) wins.
module rr_arb #(
   parameter int NREQ = 4,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant
);

   logic [IDW-1:0] idx;
   logic           found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int off = 0; off < NREQ; off++) begin
         idx = IDW'((int'(ptr) + off) % NREQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/phase_rot_arbiter.sv
// Shared K-phase rotator with round-robin arbitration and a registered valid/ready output.
// Optional per-requester grant counters are enabled by defining PHASE_ARB_STATS_EN.
module phase_rot_arbiter
   import phase_pkg::*;
#(
   parameter int BITSTREAM = 64,
   parameter int NREQ      = 4,
   parameter int IDW       = $clog2(NREQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*BITSTREAM-1:0] req_bits,
   input  logic [NREQ*2-1:0]         req_k,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [BITSTREAM-1:0]      out_bits,
   output logic [IDW-1:0]            out_id
`ifdef PHASE_ARB_STATS_EN
   ,
   output logic [NREQ*STAT_W-1:0]    stat_grants
`endif
);

   logic                 can_accept;
   logic                 xfer;
   logic [NREQ-1:0]      grant;
   logic [IDW-1:0]       rr_ptr;
   logic [IDW-1:0]       sel_id;
   logic [BITSTREAM-1:0] sel_bits;
   k_t                   sel_k;
   logic [MAX_BITS-1:0]  rot_full;

   assign can_accept = !out_valid || out_ready;

   rr_arb #(.NREQ(NREQ)) u_arb (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (grant)
   );

   // rst_n gates ready so nothing looks accepted while held in reset.
   assign req_ready = grant & {NREQ{can_accept & rst_n}};
   assign xfer      = |req_ready;

   always_comb begin
      sel_id   = '0;
      sel_bits = '0;
      sel_k    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_id   = sel_id | IDW'(i);
            sel_bits = sel_bits | req_bits[i*BITSTREAM +: BITSTREAM];
            sel_k    = sel_k | req_k[i*2 +: 2];
         end
      end
   end

   assign rot_full = rot_r(MAX_BITS'(sel_bits), BITSTREAM, sel_k);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_bits  <= '0;
         out_id    <= '0;
         rr_ptr    <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_bits  <= rot_full[BITSTREAM-1:0];
         out_id    <= sel_id;
         rr_ptr    <= IDW'((int'(sel_id) + 1) % NREQ);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef PHASE_ARB_STATS_EN
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
      logic [STAT_W-1:0] cnt;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            cnt <= '0;
         else if (req_ready[gi] && req_valid[gi] && cnt != {STAT_W{1'b1}})
            cnt <= cnt + 1'b1;
      end
      assign stat_grants[gi*STAT_W +: STAT_W] = cnt;
   end
`endif

endmodule

// File: tb/tb_phase_rot_arbiter.sv
// Directed + randomized bench for phase_rot_arbiter against a transaction-level model.
module tb_phase_rot_arbiter;
   import phase_pkg::*;

   localparam int NREQ = 4;
   localparam int BW   = 64;
   localparam int IDW  = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*BW-1:0]   req_bits;
   logic [NREQ*2-1:0]    req_k;
   logic                 out_valid;
   logic                 out_ready;
   logic [BW-1:0]        out_bits;
   logic [IDW-1:0]       out_id;
`ifdef PHASE_ARB_STATS_EN
   logic [NREQ*16-1:0]   stat_grants;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Model of what the block should hold after each edge.
   int          m_ptr;
   bit          m_valid;
   logic [BW-1:0] m_bits;
   int          m_id;
   int          m_cnt [NREQ];

   phase_rot_arbiter #(.BITSTREAM(BW), .NREQ(NREQ)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_bits   (req_bits),
      .req_k      (req_k),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_bits   (out_bits),
      .out_id     (out_id)
`ifdef PHASE_ARB_STATS_EN
      ,
      .stat_grants(stat_grants)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [BW-1:0] ref_rot(input logic [BW-1:0] b, input int k);
      if (k == 0) return b;
      return (b >> k) | (b << (BW - k));
   endfunction

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr   = 0;
      m_valid = 0;
      m_bits  = '0;
      m_id    = 0;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
   endtask

   function automatic int pick();
      for (int off = 0; off < NREQ; off++) begin
         if (req_valid[(m_ptr + off) % NREQ]) return (m_ptr + off) % NREQ;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input bit v, input logic [BW-1:0] b, input logic [1:0] k);
      req_valid[i]        = v;
      req_bits[i*BW +: BW] = b;
      req_k[i*2 +: 2]     = k;
   endtask

   task automatic rand_req(input int i, input bit v);
      set_req(i, v, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
   endtask

   // One clock: check ready against the model, advance model, check registered outputs.
   task automatic cyc(input string tag);
      int g;
      logic [NREQ-1:0] er;
      #1;
      g  = (!m_valid || out_ready) ? pick() : -1;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk({tag, ".ready"}, BW'(req_ready), BW'(er));
      if (g >= 0) begin
         m_bits  = ref_rot(req_bits[g*BW +: BW], int'(req_k[g*2 +: 2]));
         m_id    = g;
         m_valid = 1;
         m_ptr   = (g + 1) % NREQ;
         if (m_cnt[g] < 65535) m_cnt[g]++;
      end else if (out_ready) begin
         m_valid = 0;
      end
      @(posedge clk);
      #1;
      chk({tag, ".valid"}, BW'(out_valid), BW'(m_valid));
      chk({tag, ".bits"},  out_bits, m_bits);
      chk({tag, ".id"},    BW'(out_id), BW'(m_id));
`ifdef PHASE_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++)
         chk({tag, ".stat"}, BW'(stat_grants[i*16 +: 16]), BW'(16'(m_cnt[i])));
`endif
   endtask

   initial begin
      req_valid = '0;
      req_bits  = '0;
      req_k     = '0;
      out_ready = 1'b0;
      model_reset();

      // Held in reset with every requester asking.
      for (int i = 0; i < NREQ; i++) rand_req(i, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("rst.ready", BW'(req_ready), '0);
      chk("rst.valid", BW'(out_valid), '0);
      chk("rst.bits",  out_bits, '0);
      chk("rst.id",    BW'(out_id), '0);

      rst_n     = 1'b1;
      out_ready = 1'b1;
      cyc("first");
      chk("first.id0", BW'(out_id), '0);

      // Single requester, known rotations.
      req_valid = '0;
      set_req(0, 1'b1, 64'h0000_0000_0000_0001, 2'd1);
      cyc("single1");
      chk("single1.const", out_bits, 64'h8000_0000_0000_0000);
      set_req(0, 1'b1, 64'h0000_0000_0000_000F, 2'd3);
      cyc("single2");
      chk("single2.const", out_bits, 64'hE000_0000_0000_0001);

      req_valid = '0;
      cyc("drain");

      // All valid: priority walks from the slot after the last grant (req0 -> start at 1).
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < NREQ; i++) rand_req(i, 1'b1);
         cyc("rr");
         chk("rr.seq", BW'(out_id), BW'((c + 1) % NREQ));
         chk("rr.full", BW'(out_valid), 64'd1);
      end

      // Backpressure while full, then drain and accept in the same edge.
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) cyc("bp");
      out_ready = 1'b1;
      req_valid = '0;
      rand_req(2, 1'b1);
      cyc("bp_take");
      chk("bp_take.id2", BW'(out_id), 64'd2);

      // Async reset while full with pointer at 3.
      out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst.valid", BW'(out_valid), '0);
      chk("mrst.bits",  out_bits, '0);
      chk("mrst.id",    BW'(out_id), '0);
      model_reset();
      #2;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      req_valid = '0;
      rand_req(1, 1'b1);
      rand_req(3, 1'b1);
      cyc("mrst.next");
      chk("mrst.lowest", BW'(out_id), 64'd1);

      // Random traffic with random downstream stalls.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) rand_req(i, 1'($urandom_range(0, 1)));
         out_ready = ($urandom_range(0, 3) != 0);
         cyc("rnd");
      end

`ifdef PHASE_ARB_STATS_EN
      // Counter saturation from a single requester after a fresh reset.
      req_valid = '0;
      #2;
      rst_n = 1'b0;
      #2;
      model_reset();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      set_req(1, 1'b1, 64'h0123_4567_89AB_CDEF, 2'd2);
      repeat (70000) cyc("sat");
      chk("sat.c1", BW'(stat_grants[16 +: 16]), 64'hFFFF);
      chk("sat.c0", BW'(stat_grants[0 +: 16]), '0);
      chk("sat.c2", BW'(stat_grants[32 +: 16]), '0);
      chk("sat.c3", BW'(stat_grants[48 +: 16]), '0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
